// File: rtl/serial_add_seq_if.sv
// Operation request / result bundle for the bit-serial add/subtract sequencer.
interface serial_add_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] y;
  logic             co;
  logic             v;
  logic             busy;
  logic             done;

  modport master (output start, sub, a, b, input y, co, v, busy, done);
  modport slave  (input start, sub, a, b, output y, co, v, busy, done);
endinterface

// File: rtl/serial_add_seq.sv
// Bit-serial WIDTH-bit adder/subtractor: one full adder, built from two half
// adders, is reused LSB first over WIDTH clock edges.
module serial_add_seq_ha (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;
endmodule

module serial_add_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  serial_add_seq_if.slave    bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-2:0] sum_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] y_q;
  logic             co_q;
  logic             v_q;
  logic             busy_q;
  logic             done_q;

  logic             ha0_s;
  logic             ha0_c;
  logic             ha1_c;
  logic             sum_bit;
  logic             carry_d;
  logic [WIDTH-1:0] sum_d;

  serial_add_seq_ha u_ha0 (.a_i(a_sh_q[0]), .b_i(b_sh_q[0]), .s_o(ha0_s),   .c_o(ha0_c));
  serial_add_seq_ha u_ha1 (.a_i(ha0_s),     .b_i(carry_q),   .s_o(sum_bit), .c_o(ha1_c));

  assign carry_d = ha0_c | ha1_c;
  // Sum bits enter at the top so bit 0 ends up at the LSB after WIDTH shifts.
  assign sum_d   = {sum_bit, sum_q};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      y_q     <= '0;
      co_q    <= 1'b0;
      v_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            // Subtraction is A + ~B + 1: the +1 rides in as the initial carry.
            a_sh_q  <= bus.a;
            b_sh_q  <= bus.sub ? ~bus.b : bus.b;
            carry_q <= bus.sub;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          a_sh_q  <= a_sh_q >> 1;
          b_sh_q  <= b_sh_q >> 1;
          sum_q   <= sum_d[WIDTH-1:1];
          carry_q <= carry_d;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BIT) begin
            // carry_q here is the carry into the MSB.
            y_q     <= sum_d;
            co_q    <= carry_d;
            v_q     <= carry_q ^ carry_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.y    = y_q;
  assign bus.co   = co_q;
  assign bus.v    = v_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_serial_add_seq.sv
// Directed bench for serial_add_seq (WIDTH=32) with a queue-based scoreboard.
module tb_serial_add_seq;
  localparam int W = 32;

  typedef struct {
    logic [W-1:0] y;
    logic         co;
    logic         v;
    int           e0;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   errors;
  int   checks;
  int   busy_run;
  logic [W+1:0] held;
  exp_t q[$];

  serial_add_seq_if #(.WIDTH(W)) bus ();
  serial_add_seq #(.WIDTH(W)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, req, $time);
    end
  endfunction

  // Monitor: pops the scoreboard on every DONE and checks result, latency, BUSY length.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busy_run = 0;
      held     = '0;
    end else begin
      if (bus.busy) begin
        busy_run++;
        chk("result_hold_during_run", {bus.co, bus.v, bus.y}, held);
      end
      if (bus.done) begin
        chk("busy_low_with_done", bus.busy, 1'b0);
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = q.pop_front();
          chk("y",       bus.y,   e.y);
          chk("co",      bus.co,  e.co);
          chk("v",       bus.v,   e.v);
          chk("latency", cyc - e.e0, W);
          chk("busy_cycles", busy_run, W);
          held = {e.co, e.v, e.y};
        end
        busy_run = 0;
      end
    end
  end

  task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] ey, input logic eco, input logic ev, input bit track);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while ((bus.busy || bus.done) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("idle_timeout", 1, 0);
    bus.start = 1'b1;
    bus.sub   = s;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.sub   = ~s;
    bus.a     = ~a;
    bus.b     = ~b;
    if (track) begin
      e.y  = ey;
      e.co = eco;
      e.v  = ev;
      e.e0 = cyc;
      q.push_back(e);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", q.size(), 0);
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_y"},    bus.y,    '0);
    chk({tag, "_co"},   bus.co,   1'b0);
    chk({tag, "_v"},    bus.v,    1'b0);
    chk({tag, "_busy"}, bus.busy, 1'b0);
    chk({tag, "_done"}, bus.done, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    errors    = 0;
    checks    = 0;
    busy_run  = 0;
    held      = '0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(negedge clk);
    check_zero("reset_init");
    #2 rst_n = 1'b1;

    issue(1'b0, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0, 1'b0, 1'b1);
    drain();
    issue(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    drain();
    issue(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b1);
    drain();

    // Asynchronous clear of a non-zero result while idle.
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1 check_zero("reset_async_idle");
    @(negedge clk);
    #2 rst_n = 1'b1;

    issue(1'b1, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1);
    drain();
    issue(1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1);
    drain();
    issue(1'b1, 32'h0000_0009, 32'h0000_0009, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    drain();
    issue(1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b1);
    drain();

    // START during RUN must be ignored.
    issue(1'b0, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1'b0, 1'b0, 1'b1);
    repeat (9) @(negedge clk);
    bus.start = 1'b1;
    bus.sub   = 1'b1;
    bus.a     = 32'd9;
    bus.b     = 32'd9;
    @(negedge clk);
    bus.start = 1'b0;
    drain();
    repeat (40) @(negedge clk);
    chk("ignored_start_busy", bus.busy, 1'b0);

    // Reset in the middle of RUN abandons the operation.
    issue(1'b0, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("reset_mid_run");
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_no_done", bus.done, 1'b0);
    issue(1'b0, 32'h0000_0002, 32'h0000_0002, 32'h0000_0004, 1'b0, 1'b0, 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
